// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: PC register and fetch issue feeding a DEPTH-entry valid/ready queue toward decode
module fetch_queue_stage #(
    parameter int XLEN = 32,
    parameter int ILEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int PC_STEP = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pc_write,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [ILEN-1:0]            imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ILEN-1:0]            out_instr,
    output logic [XLEN-1:0]            out_pc_next,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [XLEN-1:0] pc, inflight_pc;
    logic            inflight, push, pop;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW:0]     occ;
    logic [ILEN-1:0] q_instr [DEPTH];
    logic [XLEN-1:0] q_pcn [DEPTH];
    always_comb begin
        occ = {1'b0, count} + (CW+1)'(inflight);
        imem_req = !rst && pc_write && !redirect && occ < (CW+1)'(DEPTH);
        push = inflight && !redirect;
        out_valid = !rst && count != '0;
        pop = out_valid && out_ready;
        out_instr = out_valid ? q_instr[rd_ptr] : '0;
        out_pc_next = out_valid ? q_pcn[rd_ptr] : '0;
    end
    assign imem_addr = pc;
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            inflight <= 1'b0;
            inflight_pc <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else if (redirect) begin
            pc <= redirect_pc;
            inflight <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (imem_req) pc <= pc + XLEN'(PC_STEP);
            inflight <= imem_req;
            inflight_pc <= pc;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pcn[wr_ptr] <= inflight_pc + XLEN'(PC_STEP);
        end
    end
endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb_fetch_queue_stage: directed stimulus with a popped-output scoreboard for fetch_queue_stage
module tb_fetch_queue_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_write = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc_next;
    logic [2:0]  count;
    int          passed = 0;
    int          total = 0;
    logic [31:0] exp_instr[$];
    logic [31:0] exp_pcn[$];

    fetch_queue_stage dut (
        .clk(clk), .rst(rst), .pc_write(pc_write), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc_next(out_pc_next), .count(count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) imem_rdata <= imem_addr >> 2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [31:0] instr, input logic [31:0] pcn);
        exp_instr.push_back(instr);
        exp_pcn.push_back(pcn);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        tick();
        tick();
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_pcn", out_pc_next, 0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_instr.size() != 0; i++) tick();
        chk(name, exp_instr.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && !redirect && out_valid && out_ready) begin
            if (exp_instr.size() == 0) begin
                chk("unexpected_pop", out_instr, 32'hDEAD_BEEF);
            end else begin
                chk("sb_instr", out_instr, exp_instr.pop_front());
                chk("sb_pc_next", out_pc_next, exp_pcn.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nreq;
        // 1: reset release and steady streaming
        out_ready = 1'b1;
        pc_write = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) expect_out(i, 4 * (i + 1));
        rst = 1'b0;
        #1;
        chk("t1_req0", 32'(imem_req), 1);
        chk("t1_addr0", imem_addr, 0);
        chk("t1_valid0", 32'(out_valid), 0);
        tick();
        chk("t1_addr1", imem_addr, 4);
        chk("t1_valid1", 32'(out_valid), 0);
        tick();
        chk("t1_addr2", imem_addr, 8);
        chk("t1_valid2", 32'(out_valid), 1);
        repeat (4) tick();
        pc_write = 1'b0;
        drain("t1_drain");

        // 2: backpressure fills queue, exactly DEPTH requests
        out_ready = 1'b0;
        pc_write = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) expect_out(i, 4 * (i + 1));
        rst = 1'b0;
        nreq = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (imem_req) begin
                chk("t2_addr", imem_addr, 32'(4 * nreq));
                nreq++;
            end
            tick();
        end
        chk("t2_nreq", 32'(nreq), 4);
        chk("t2_count", 32'(count), 4);
        chk("t2_req_full", 32'(imem_req), 0);
        out_ready = 1'b1;
        #1;
        chk("t2_req_pop", 32'(imem_req), 0);
        tick();
        chk("t2_req_resume", 32'(imem_req), 1);
        chk("t2_addr_resume", imem_addr, 16);
        tick();
        pc_write = 1'b0;
        drain("t2_drain");

        // 3: redirect with three queued and one in flight
        out_ready = 1'b0;
        pc_write = 1'b1;
        do_reset();
        expect_out(32'h40, 32'h104);
        expect_out(32'h41, 32'h108);
        rst = 1'b0;
        repeat (4) tick();
        chk("t3_count3", 32'(count), 3);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        #1;
        chk("t3_req_redir", 32'(imem_req), 0);
        tick();
        redirect = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("t3_count0", 32'(count), 0);
        chk("t3_valid0", 32'(out_valid), 0);
        chk("t3_req", 32'(imem_req), 1);
        chk("t3_addr", imem_addr, 32'h100);
        tick();
        tick();
        pc_write = 1'b0;
        drain("t3_drain");

        // 4: three-cycle stall mid-stream
        pc_write = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) expect_out(i, 4 * (i + 1));
        rst = 1'b0;
        repeat (4) tick();
        pc_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_stall_req", 32'(imem_req), 0);
            chk("t4_stall_addr", imem_addr, 16);
            tick();
        end
        pc_write = 1'b1;
        #1;
        chk("t4_resume_req", 32'(imem_req), 1);
        chk("t4_resume_addr", imem_addr, 16);
        tick();
        tick();
        pc_write = 1'b0;
        drain("t4_drain");

        // 5: redirect beats stall, then reset mid-stream
        pc_write = 1'b1;
        do_reset();
        expect_out(0, 4);
        rst = 1'b0;
        repeat (3) tick();
        redirect = 1'b1;
        redirect_pc = 32'h200;
        pc_write = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("t5_req_redir", 32'(imem_req), 0);
        tick();
        redirect = 1'b0;
        pc_write = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("t5_req", 32'(imem_req), 1);
        chk("t5_addr", imem_addr, 32'h200);
        chk("t5_count", 32'(count), 0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(out_valid), 0);
        chk("t5_rst_req", 32'(imem_req), 0);
        tick();
        rst = 1'b0;
        pc_write = 1'b0;
        #1;
        chk("t5_post_count", 32'(count), 0);
        chk("t5_post_pc", imem_addr, 0);
        chk("t5_post_valid", 32'(out_valid), 0);
        drain("t5_drain");

        // 6: PC wraps around the top of the address space
        pc_write = 1'b0;
        do_reset();
        expect_out(32'h3FFF_FFFF, 32'h0);
        expect_out(32'h0, 32'h4);
        rst = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        pc_write = 1'b1;
        #1;
        chk("t6_req", 32'(imem_req), 1);
        chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("t6_addr_wrap", imem_addr, 32'h0);
        tick();
        pc_write = 1'b0;
        drain("t6_drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
